// File: rtl/aidc_lite_ahb_rd_dma.sv
// aidc_lite_ahb_rd_dma: AHB2 INCR4 burst-read engine feeding 32-bit words to the compressor stream.
// Latency: first word on rdata_o 5 cycles after start_i (immediate grant, zero-wait slave).
// Backpressure: a burst is requested only with 4 free FIFO slots; rready_i low stalls fetching.
module aidc_lite_ahb_rd_dma #(
  parameter int FIFO_DEPTH = 8,
  parameter int CNT_W      = 16
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start_i,
  input  logic [31:0]      src_addr_i,
  input  logic [CNT_W-1:0] burst_cnt_i,
  output logic             hbusreq_o,
  input  logic             hgrant_i,
  output logic [31:0]      haddr_o,
  output logic [1:0]       htrans_o,
  output logic             hwrite_o,
  output logic [2:0]       hsize_o,
  output logic [2:0]       hburst_o,
  output logic [3:0]       hprot_o,
  output logic [31:0]      hwdata_o,
  input  logic [31:0]      hrdata_i,
  input  logic             hready_i,
  input  logic [1:0]       hresp_i,
  output logic [31:0]      rdata_o,
  output logic             rvalid_o,
  input  logic             rready_i,
  output logic             busy_o,
  output logic             done_o,
  output logic             err_o
);
  localparam int AW = $clog2(FIFO_DEPTH);
  localparam int CW = AW + 1;
  localparam logic [CW-1:0] DEPTH_V = CW'(FIFO_DEPTH);

  typedef enum logic [2:0] {
    S_IDLE, S_WAIT_SPACE, S_REQ, S_BURST, S_DRAIN_DATA, S_FINISH
  } state_t;
  state_t state, state_nxt;

  logic [31:0]      addr;      // next address to present
  logic [CNT_W-1:0] cnt;       // bursts still to fetch
  logic [1:0]       abeat;     // addresses accepted in this burst
  logic [1:0]       dbeat;     // data beats captured in this burst
  logic             issue;     // we own the address bus and present a transfer
  logic             first;     // next presented beat is NONSEQ
  logic             resumed;   // burst was broken by grant loss; remaining beats use INCR
  logic             dphase;    // an accepted address awaits its data
  logic             busy, done, err;

  logic [31:0]   mem [FIFO_DEPTH];
  logic [AW-1:0] wr_ptr, rd_ptr;
  logic [CW-1:0] fifo_cnt, free;
  logic          push, pop, acc, err_hit, last_data, space_ok;

  assign acc       = issue & hready_i;
  assign push      = dphase & hready_i;
  // first cycle of a two-cycle non-OKAY response (RETRY/SPLIT included)
  assign err_hit   = dphase & ~hready_i & (hresp_i != 2'b00);
  assign last_data = push & (dbeat == 2'd3);
  assign pop       = rvalid_o & rready_i;
  // a word leaving this cycle already counts as a free slot
  assign free      = DEPTH_V - fifo_cnt + {{(CW-1){1'b0}}, pop};
  assign space_ok  = (free >= CW'(4));

  assign haddr_o  = addr;
  assign hwrite_o = 1'b0;
  assign hsize_o  = 3'b010;
  assign hburst_o = resumed ? 3'b001 : 3'b011;
  assign hprot_o  = 4'b0011;
  assign hwdata_o = 32'h0;
  assign rdata_o  = mem[rd_ptr];
  assign rvalid_o = (fifo_cnt != '0);
  assign busy_o   = busy;
  assign done_o   = done;
  assign err_o    = err;

  // state register
  always_ff @(posedge clk or posedge rst) begin
    if (rst) state <= S_IDLE;
    else     state <= state_nxt;
  end

  // next-state and bus request/transfer-type decode
  always_comb begin
    state_nxt = state;
    hbusreq_o = (state == S_REQ) || (state == S_BURST);
    htrans_o  = issue ? (first ? 2'b10 : 2'b11) : 2'b00;
    case (state)
      S_IDLE:       if (start_i) state_nxt = (burst_cnt_i == '0) ? S_FINISH : S_WAIT_SPACE;
      S_WAIT_SPACE: if (space_ok) state_nxt = S_REQ;
      S_REQ:        if (hgrant_i && hready_i) state_nxt = S_BURST;
      S_BURST: begin
        if (err_hit)                     state_nxt = S_FINISH;
        else if (acc && abeat == 2'd3)   state_nxt = S_DRAIN_DATA;
      end
      S_DRAIN_DATA: begin
        if (err_hit)        state_nxt = S_FINISH;
        else if (last_data) state_nxt = (cnt == CNT_W'(1)) ? S_FINISH : S_WAIT_SPACE;
      end
      S_FINISH:     state_nxt = S_IDLE;
      default:      state_nxt = S_IDLE;
    endcase
  end

  // transfer bookkeeping: address/beat counters, data-phase tracking and status
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      addr    <= '0;
      cnt     <= '0;
      abeat   <= '0;
      dbeat   <= '0;
      issue   <= 1'b0;
      first   <= 1'b0;
      resumed <= 1'b0;
      dphase  <= 1'b0;
      busy    <= 1'b0;
      done    <= 1'b0;
      err     <= 1'b0;
    end else begin
      done <= (state == S_FINISH);
      if (state == S_FINISH) busy <= 1'b0;
      if (state == S_IDLE && start_i) begin
        addr <= src_addr_i;
        cnt  <= burst_cnt_i;
        err  <= 1'b0;
        busy <= 1'b1;
      end
      if (state == S_REQ && hgrant_i && hready_i) begin
        issue   <= 1'b1;
        first   <= 1'b1;
        resumed <= 1'b0;
        abeat   <= '0;
        dbeat   <= '0;
      end
      if (acc) begin
        addr  <= addr + 32'd4;
        abeat <= abeat + 2'd1;
        first <= 1'b0;
        // last address of the burst, or grant lost: let this beat finish, then go idle
        if (abeat == 2'd3 || !hgrant_i) issue <= 1'b0;
      end else if (state == S_BURST && !issue && hready_i && hgrant_i) begin
        issue   <= 1'b1;
        first   <= 1'b1;
        resumed <= 1'b1;
      end
      if (hready_i)  dphase <= acc;
      if (push)      dbeat  <= dbeat + 2'd1;
      if (last_data) cnt    <= cnt - CNT_W'(1);
      if (err_hit) begin
        err    <= 1'b1;
        issue  <= 1'b0;
        dphase <= 1'b0;
      end
    end
  end

  // FIFO storage; entries need no reset because occupancy gates visibility
  always_ff @(posedge clk) begin
    if (push) mem[wr_ptr] <= hrdata_i;
  end

  // FIFO pointers and occupancy
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wr_ptr   <= '0;
      rd_ptr   <= '0;
      fifo_cnt <= '0;
    end else begin
      if (push) wr_ptr <= wr_ptr + AW'(1);
      if (pop)  rd_ptr <= rd_ptr + AW'(1);
      if (push && !pop)      fifo_cnt <= fifo_cnt + CW'(1);
      else if (pop && !push) fifo_cnt <= fifo_cnt - CW'(1);
    end
  end

  // the 4-slot credit check must make a push into a full FIFO impossible
  assert property (@(posedge clk) disable iff (rst) !(push && (fifo_cnt == DEPTH_V)));

endmodule

// File: tb/tb_aidc_lite_ahb_rd_dma.sv
`timescale 1ns/1ps
module tb_aidc_lite_ahb_rd_dma;
  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        start = 1'b0;
  logic [31:0] src_addr = '0;
  logic [15:0] burst_cnt = '0;
  logic        hbusreq;
  logic        hgrant = 1'b1;
  logic [31:0] haddr;
  logic [1:0]  htrans;
  logic        hwrite;
  logic [2:0]  hsize, hburst;
  logic [3:0]  hprot;
  logic [31:0] hwdata, hrdata;
  logic        hready;
  logic [1:0]  hresp;
  logic [31:0] rdata;
  logic        rvalid;
  logic        rready = 1'b0;
  logic        busy, done, err;

  aidc_lite_ahb_rd_dma #(.FIFO_DEPTH(8), .CNT_W(16)) dut (
    .clk(clk), .rst(rst), .start_i(start), .src_addr_i(src_addr), .burst_cnt_i(burst_cnt),
    .hbusreq_o(hbusreq), .hgrant_i(hgrant), .haddr_o(haddr), .htrans_o(htrans),
    .hwrite_o(hwrite), .hsize_o(hsize), .hburst_o(hburst), .hprot_o(hprot),
    .hwdata_o(hwdata), .hrdata_i(hrdata), .hready_i(hready), .hresp_i(hresp),
    .rdata_o(rdata), .rvalid_o(rvalid), .rready_i(rready),
    .busy_o(busy), .done_o(done), .err_o(err)
  );

  always #5 clk = ~clk;

  // AHB slave: zero-wait, data = ~address; optional two-cycle ERROR on one address
  logic        dp_vld;
  logic [31:0] dp_addr;
  logic [1:0]  eph;
  logic        err_en = 1'b0;
  logic [31:0] err_addr = '0;
  assign hready = (eph != 2'd1);
  assign hresp  = (eph != 2'd0) ? 2'b01 : 2'b00;
  assign hrdata = dp_vld ? ~dp_addr : 32'h0;
  always @(posedge clk or posedge rst) begin
    if (rst) begin
      dp_vld <= 1'b0; dp_addr <= '0; eph <= 2'd0;
    end else if (eph == 2'd1) begin
      eph <= 2'd2;
    end else begin
      eph     <= 2'd0;
      dp_vld  <= htrans[1];
      dp_addr <= haddr;
      if (htrans[1] && err_en && haddr == err_addr) eph <= 2'd1;
    end
  end

  int vec = 0, miss = 0, done_cnt = 0, req_cnt = 0;
  logic [36:0] bus_log[$];
  logic [31:0] rx[$];

  // observers on the falling edge: accepted transfers, popped words, done pulses
  always @(negedge clk) begin
    if (!rst) begin
      if (hready && htrans[1]) bus_log.push_back({htrans, hburst, haddr});
      if (rvalid && rready)    rx.push_back(rdata);
      if (done)                done_cnt++;
      if (hbusreq)             req_cnt++;
    end
  end

  initial begin
    #100000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1);
  end

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    vec++;
    assert (obs === exp) else begin
      miss++;
      $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
    end
  endtask

  task automatic tick(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic kick(input logic [31:0] a, input logic [15:0] c);
    start = 1'b1; src_addr = a; burst_cnt = c;
    tick(1);
    start = 1'b0;
  endtask

  task automatic wait_done(input string tag, input int lim);
    int n = 0;
    int d = done_cnt;
    while (done_cnt == d && n < lim) begin tick(1); n++; end
    chk(tag, done_cnt - d, 1);
  endtask

  task automatic wait_trans(input string tag, input logic [1:0] t, input int lim);
    int n = 0;
    while (htrans !== t && n < lim) begin tick(1); n++; end
    chk(tag, htrans, t);
  endtask

  function automatic logic [36:0] be(input logic [1:0] t, input logic [2:0] b, input logic [31:0] a);
    return {t, b, a};
  endfunction

  initial begin
    int d0, r0, n;
    logic [31:0] a, w;

    // reset values
    tick(3);
    chk("rst_hbusreq", hbusreq, 0);
    chk("rst_htrans", htrans, 2'b00);
    chk("rst_haddr", haddr, 32'h0);
    chk("rst_hburst", hburst, 3'b011);
    chk("rst_rvalid", rvalid, 0);
    chk("rst_busy", busy, 0);
    chk("rst_done", done, 0);
    chk("rst_err", err, 0);
    chk("const_hwrite", hwrite, 0);
    chk("const_hsize", hsize, 3'b010);
    chk("const_hprot", hprot, 4'b0011);
    chk("const_hwdata", hwdata, 32'h0);
    rst = 1'b0; hgrant = 1'b1; rready = 1'b1;
    tick(2);

    // single INCR4 burst
    bus_log.delete(); rx.delete(); d0 = done_cnt;
    kick(32'h1000_0000, 16'd1);
    wait_done("t1_done_wait", 100);
    tick(6);
    chk("t1_nbeats", bus_log.size(), 4);
    chk("t1_nwords", rx.size(), 4);
    for (int i = 0; i < 4; i++) begin
      a = 32'h1000_0000 + 4 * i;
      w = ~a;
      chk("t1_bus", bus_log[i], be((i == 0) ? 2'b10 : 2'b11, 3'b011, a));
      chk("t1_word", rx[i], w);
    end
    chk("t1_done_count", done_cnt - d0, 1);
    chk("t1_err", err, 0);
    chk("t1_busy", busy, 0);

    // FIFO credit stall: only two bursts fit while the stream is blocked
    bus_log.delete(); rx.delete(); d0 = done_cnt; rready = 1'b0;
    kick(32'h2000_0000, 16'd3);
    tick(60);
    chk("t2_stall_beats", bus_log.size(), 8);
    chk("t2_stall_busy", busy, 1);
    chk("t2_stall_req", hbusreq, 0);
    chk("t2_stall_htrans", htrans, 2'b00);
    chk("t2_stall_rvalid", rvalid, 1);
    chk("t2_stall_nodone", done_cnt - d0, 0);
    rready = 1'b1;
    wait_done("t2_done_wait", 200);
    tick(16);
    chk("t2_nbeats", bus_log.size(), 12);
    chk("t2_nwords", rx.size(), 12);
    for (int i = 0; i < 12; i++) begin
      a = 32'h2000_0000 + 4 * i;
      w = ~a;
      chk("t2_bus", bus_log[i], be((i % 4 == 0) ? 2'b10 : 2'b11, 3'b011, a));
      chk("t2_word", rx[i], w);
    end

    // grant lost after beat 1, resumed as INCR
    bus_log.delete(); rx.delete(); d0 = done_cnt;
    kick(32'h3000_0000, 16'd1);
    wait_trans("t3_wait_seq", 2'b11, 20);
    hgrant = 1'b0;
    tick(1);
    chk("t3_idle", htrans, 2'b00);
    chk("t3_req_held", hbusreq, 1);
    chk("t3_next_addr", haddr, 32'h3000_0008);
    tick(2);
    chk("t3_idle_hold", htrans, 2'b00);
    chk("t3_req_hold", hbusreq, 1);
    hgrant = 1'b1;
    tick(1);
    chk("t3_resume_trans", htrans, 2'b10);
    chk("t3_resume_addr", haddr, 32'h3000_0008);
    chk("t3_resume_burst", hburst, 3'b001);
    wait_done("t3_done_wait", 50);
    tick(6);
    chk("t3_nbeats", bus_log.size(), 4);
    chk("t3_nwords", rx.size(), 4);
    for (int i = 0; i < 4; i++) begin
      a = 32'h3000_0000 + 4 * i;
      w = ~a;
      chk("t3_bus", bus_log[i], be((i == 0 || i == 2) ? 2'b10 : 2'b11, (i < 2) ? 3'b011 : 3'b001, a));
      chk("t3_word", rx[i], w);
    end
    chk("t3_err", err, 0);

    // ERROR on beat 2 of the first of two bursts
    bus_log.delete(); rx.delete(); d0 = done_cnt;
    err_addr = 32'h4000_0008; err_en = 1'b1;
    kick(32'h4000_0000, 16'd2);
    n = 0;
    while (hready !== 1'b0 && n < 30) begin tick(1); n++; end
    chk("t4_err_cycle", hready, 0);
    chk("t4_err_not_yet", err, 0);
    tick(1);
    chk("t4_idle_after", htrans, 2'b00);
    chk("t4_req_dropped", hbusreq, 0);
    chk("t4_err_set", err, 1);
    wait_done("t4_done_wait", 20);
    tick(20);
    err_en = 1'b0;
    chk("t4_nbeats", bus_log.size(), 3);
    chk("t4_nwords", rx.size(), 2);
    w = ~32'h4000_0000;
    chk("t4_word0", rx[0], w);
    w = ~32'h4000_0004;
    chk("t4_word1", rx[1], w);
    chk("t4_done_count", done_cnt - d0, 1);
    chk("t4_err_sticky", err, 1);

    // zero count, plus a start during busy that must be ignored
    bus_log.delete(); rx.delete(); d0 = done_cnt; r0 = req_cnt;
    kick(32'h5000_0000, 16'd0);
    chk("t5_busy1", busy, 1);
    chk("t5_done1", done, 0);
    chk("t5_err_cleared", err, 0);
    start = 1'b1; src_addr = 32'hDEAD_BEE0; burst_cnt = 16'd5;
    tick(1);
    start = 1'b0;
    chk("t5_done2", done, 1);
    chk("t5_busy2", busy, 0);
    chk("t5_addr_kept", haddr, 32'h5000_0000);
    tick(1);
    chk("t5_done3", done, 0);
    chk("t5_busy3", busy, 0);
    tick(10);
    chk("t5_nobus", bus_log.size(), 0);
    chk("t5_noreq", req_cnt - r0, 0);
    chk("t5_done_count", done_cnt - d0, 1);

    // asynchronous reset in the middle of a burst, then a clean restart
    bus_log.delete(); rx.delete(); rready = 1'b0;
    kick(32'h6000_0000, 16'd2);
    wait_trans("t6_wait_seq", 2'b11, 20);
    tick(1);
    chk("t6_pre_rvalid", rvalid, 1);
    chk("t6_pre_busy", busy, 1);
    rst = 1'b1;
    #2;
    chk("t6_rst_htrans", htrans, 2'b00);
    chk("t6_rst_hbusreq", hbusreq, 0);
    chk("t6_rst_haddr", haddr, 32'h0);
    chk("t6_rst_hburst", hburst, 3'b011);
    chk("t6_rst_rvalid", rvalid, 0);
    chk("t6_rst_busy", busy, 0);
    chk("t6_rst_done", done, 0);
    chk("t6_rst_err", err, 0);
    tick(2);
    rst = 1'b0; rready = 1'b1;
    bus_log.delete(); rx.delete();
    tick(1);
    kick(32'h7000_0000, 16'd1);
    wait_done("t6_done_wait", 50);
    tick(6);
    chk("t6_nbeats", bus_log.size(), 4);
    chk("t6_nwords", rx.size(), 4);
    for (int i = 0; i < 4; i++) begin
      a = 32'h7000_0000 + 4 * i;
      w = ~a;
      chk("t6_bus", bus_log[i], be((i == 0) ? 2'b10 : 2'b11, 3'b011, a));
      chk("t6_word", rx[i], w);
    end

    $display("== %0d vectors applied, %0d miscompares ==", vec, miss);
    $finish;
  end
endmodule

// File: doc/aidc_lite_ahb_rd_dma.md
Name: aidc_lite_ahb_rd_dma

Overview:
AHB2 burst-read engine that fetches the raw source block from system memory and streams 32-bit words into the compressor datapath. It is programmed by a start pulse with a source address and a burst count from the APB config stage. It issues INCR4 read bursts only while its internal FIFO has room, and presents words on a valid/ready stream. It reports busy, done and bus-error status back to the control registers.

Parameters:
FIFO_DEPTH, 8, output FIFO depth in 32-bit words; power of 2, minimum 4
CNT_W, 16, width of burst-count input

Ports:
clk  input  1  clock
rst  input  1  reset, asynchronous, active-high
start_i  input  1  one-cycle start pulse; ignored while busy_o=1
src_addr_i  input  32  source byte address; bits [3:0] must be 0; sampled on start_i
burst_cnt_i  input  CNT_W  number of 16-byte INCR4 bursts; sampled on start_i
hbusreq_o  output  1  AHB bus request
hgrant_i  input  1  AHB grant
haddr_o  output  32  AHB address
htrans_o  output  2  AHB transfer type
hwrite_o  output  1  constant 0
hsize_o  output  3  constant 3'b010 (word)
hburst_o  output  3  3'b011 INCR4; 3'b001 INCR on a resumed burst
hprot_o  output  4  constant 4'b0011
hwdata_o  output  32  constant 0
hrdata_i  input  32  AHB read data
hready_i  input  1  AHB ready
hresp_i  input  2  AHB response
rdata_o  output  32  stream data (FIFO head)
rvalid_o  output  1  stream valid
rready_i  input  1  stream ready
busy_o  output  1  high from the cycle after start_i until the cycle done_o pulses
done_o  output  1  one-cycle completion pulse
err_o  output  1  sticky bus error; cleared by the next accepted start_i

Behaviour:
- Reset values: hbusreq_o=0, htrans_o=IDLE (2'b00), haddr_o=0, hburst_o=INCR4, rvalid_o=0, busy_o=0, done_o=0, err_o=0. The FIFO and all counters are cleared. Reset asserted mid-burst abandons the transfer immediately, and the block drives IDLE from the reset assertion onward.
- States: IDLE, WAIT_SPACE, REQ, BURST, DRAIN_DATA, FINISH.
- IDLE: start_i latches the address and count, and clears err_o. A count of 0 goes directly to FINISH, so done_o rises 2 cycles after start_i with no bus activity. A count above 0 goes to WAIT_SPACE.
- WAIT_SPACE: move to REQ when FIFO free entries >= 4. Free entries = FIFO_DEPTH - occupancy. A word popped in the same cycle counts as freed.
- REQ: hbusreq_o=1. When hgrant_i=1 and hready_i=1 are sampled at a rising edge, move to BURST.
- BURST address phase:
  - Beat 0 drives NONSEQ and beats 1-3 drive SEQ.
  - haddr advances +4 on each edge where hready_i=1.
  - After the 4th address is accepted, htrans=IDLE and hbusreq_o falls; move to DRAIN_DATA.
- Data capture: a beat's data is pushed into the FIFO on the first edge with hready_i=1 after its address was accepted. Read latency from address acceptance is at least 1 cycle.
- Grant loss: if hgrant_i=0 is sampled with hready_i=1 during BURST, the currently accepted address completes. The block then drives IDLE and keeps hbusreq_o=1. On regrant, it resumes the remaining beats at the next address: first beat NONSEQ, with hburst_o=INCR.
- DRAIN_DATA: after the last data beat is captured, decrement the burst count. If the count is nonzero, go to WAIT_SPACE; otherwise go to FINISH.
- FINISH: done_o=1 for one cycle, busy_o falls the same cycle, then go to IDLE. The FIFO may still hold words, and they continue to drain.
- Error: hresp_i other than OKAY (00), seen with hready_i=0, is the first cycle of an error response.
  - On that cycle, drive htrans=IDLE on the next cycle and drop hbusreq_o.
  - Discard the errored beat and any later beats; set err_o and go to FINISH.
  - Words already in the FIFO remain valid.
  - RETRY and SPLIT are treated as errors.
- FIFO:
  - rvalid_o = (occupancy != 0); pop on rvalid_o && rready_i.
  - Simultaneous push and pop leaves occupancy unchanged.
  - Overflow cannot occur because of the 4-entry credit check. A push into a full FIFO is a design error (assertion).
- Address wrap: a 32-bit address increment wraps modulo 2^32. No 1 KB boundary check is performed; software guarantees alignment.

Test Plan:
- Reset, then start with addr=0x1000_0000, cnt=1, hgrant=1, zero-wait slave -> NONSEQ 0x10000000, then SEQ 0x...04/08/0C, hburst=011. Four words appear in order on rdata_o; done_o pulses once; err_o=0.
- cnt=3, FIFO_DEPTH=8, rready_i=0 -> exactly 2 bursts are fetched and the block stalls in WAIT_SPACE. Raising rready_i releases the 3rd burst; 12 words are received in address order.
- Grant dropped after beat 1 is accepted -> IDLE is driven and hbusreq stays 1. On regrant, NONSEQ at addr+8 with hburst=001, then SEQ addr+C; 4 words are received.
- ERROR on beat 2 of burst 1 of cnt=2 -> htrans=IDLE the cycle after the first error cycle and err_o=1. Only words 0 and 1 are output; done_o pulses; burst 2 is never issued.
- cnt=0 start -> no hbusreq_o, done_o 2 cycles after start_i. A start_i during busy is ignored, and its address is not latched.
- Reset asserted mid-burst -> all outputs return to reset values asynchronously and the FIFO is empty. A new start after reset completes normally.
